// File: rtl/mem_io_responder.sv
// Far-end memory/IO responder for the CPU byte bus: 128KB RAM, a UART byte FIFO pair,
// a free-running cycle counter with coherent snapshot, and the sticky program-stop flag.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IN_FIFO_DEPTH  = 16,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_done
);

  localparam int IW = $clog2(IN_FIFO_DEPTH);
  localparam int OW = $clog2(OUT_FIFO_DEPTH);
  localparam logic [IW:0]   IN_FULL  = (IW+1)'(IN_FIFO_DEPTH);
  localparam logic [OW:0]   OUT_FULL = (OW+1)'(OUT_FIFO_DEPTH);
  localparam logic [18:0]   RAM_TOP  = 19'(2**RAM_ADDR_WIDTH);
  localparam logic [17:0]   A_UART   = 18'h30000;
  localparam logic [17:0]   A_CNT0   = 18'h30004;
  localparam logic [17:0]   A_CNT1   = 18'h30005;
  localparam logic [17:0]   A_CNT2   = 18'h30006;
  localparam logic [17:0]   A_CNT3   = 18'h30007;

  logic [17:0] a18;
  logic        unused_addr;
  logic        io_sel, ram_sel, rd_en, wr_en;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  assign a18         = cpu_a[17:0];
  assign unused_addr = ^cpu_a[31:18];
  assign io_sel      = (a18[17:16] == 2'b11);
  assign ram_sel     = !io_sel && ({1'b0, a18} < RAM_TOP);
  assign ram_idx     = a18[RAM_ADDR_WIDTH-1:0];
  // A stalled cycle (cpu_rdy=0) is not an access: no reads, writes, pops or pushes.
  assign rd_en       = cpu_rdy && !cpu_wr;
  assign wr_en       = cpu_rdy && cpu_wr;

  // ---------------- RAM ----------------
  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (wr_en && ram_sel) ram[ram_idx] <= cpu_dout;
    if (rd_en && ram_sel) ram_q <= ram[ram_idx];
  end

  // ---------------- counter ----------------
  logic [31:0] cnt, snap;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt <= 32'd0;
    else           cnt <= cnt + 32'd1;
  end

  // Handshakes: a byte moves on any rising edge where valid && ready; valid never waits on ready.
  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [IN_FIFO_DEPTH];
  logic [IW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [IW:0]   rx_cnt;
  logic          rx_empty, rx_push, rx_pop;

  assign rx_empty = (rx_cnt == '0);
  assign rx_ready = (rx_cnt != IN_FULL);
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_en && (a18 == A_UART) && !rx_empty;

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + IW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + IW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (IW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (IW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [OUT_FIFO_DEPTH];
  logic [OW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [OW:0]   tx_cnt;
  logic          tx_push, tx_pop;
  logic [7:0]    tx_push_data;

  assign tx_valid     = (tx_cnt != '0);
  assign tx_data      = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
  assign cpu_rdy      = (tx_cnt != OUT_FULL);
  assign tx_pop       = tx_valid && tx_ready;
  // cpu_rdy gates wr_en, so a push can never land on a full FIFO.
  assign tx_push      = wr_en && (((a18 == A_UART) && (cpu_dout != 8'h00)) ||
                                  ((a18 == A_CNT0) && !prog_done));
  assign tx_push_data = (a18 == A_CNT0) ? 8'h00 : cpu_dout;

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      prog_done <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + OW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + OW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (OW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (OW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (wr_en && (a18 == A_CNT0)) prog_done <= 1'b1;
    end
  end

  // ---------------- read data path ----------------
  logic [7:0] io_rdata, io_q;
  logic       rd_ram_q;

  always_comb begin
    io_rdata = 8'h00;
    if      (a18 == A_UART) io_rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
    else if (a18 == A_CNT0) io_rdata = cnt[7:0];
    else if (a18 == A_CNT1) io_rdata = snap[15:8];
    else if (a18 == A_CNT2) io_rdata = snap[23:16];
    else if (a18 == A_CNT3) io_rdata = snap[31:24];
  end

  // RAM data comes straight from the un-reset RAM register; the select flag decides which
  // source cpu_din shows, so reset still forces cpu_din to zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ram_q <= 1'b0;
      io_q     <= 8'h00;
      snap     <= 32'd0;
    end else if (rd_en) begin
      rd_ram_q <= ram_sel;
      io_q     <= io_rdata;
      if (a18 == A_CNT0) snap <= cnt;
    end
  end

  assign cpu_din = rd_ram_q ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, RX/TX FIFOs, backpressure, counter snapshot,
// program-stop flag and mid-operation reset.
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0002_0000;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] cpu_a = IDLE_A;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        prog_done;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_done(prog_done)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a = a; cpu_wr = wr; cpu_dout = d;
    tick();
    cpu_a = IDLE_A; cpu_wr = 1'b0; cpu_dout = 8'h00;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_total++; if (cpu_din !== 8'h00) $display("FAIL rst_cpu_din got %h exp 00", cpu_din); else n_pass++;
    n_total++; if (cpu_rdy !== 1'b1) $display("FAIL rst_cpu_rdy got %b exp 1", cpu_rdy); else n_pass++;
    n_total++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready got %b exp 1", rx_ready); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got %h exp 00", tx_data); else n_pass++;
    n_total++; if (prog_done !== 1'b0) $display("FAIL rst_prog_done got %b exp 0", prog_done); else n_pass++;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_ram();
    bus(32'h10, 1'b1, 8'h5A);
    bus(32'h10, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h5A) $display("FAIL ram_rd_after_wr got %h exp 5a", cpu_din); else n_pass++;
    bus(32'h1FFFF, 1'b1, 8'hC3);
    bus(32'h00000, 1'b1, 8'h11);
    bus(32'h20000, 1'b1, 8'h77);
    bus(32'h1FFFF, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'hC3) $display("FAIL ram_top got %h exp c3", cpu_din); else n_pass++;
    bus(32'h00000, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h11) $display("FAIL ram_hole_alias got %h exp 11", cpu_din); else n_pass++;
    bus(32'h20000, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h00) $display("FAIL hole_rd got %h exp 00", cpu_din); else n_pass++;
    bus(32'h10, 1'b0, 8'h00);
    bus(32'h30008, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h00) $display("FAIL io_other_rd got %h exp 00", cpu_din); else n_pass++;
  endtask

  task automatic test_rx();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h00;
    rx_push(8'h41);
    rx_push(8'h42);
    for (int i = 0; i < 3; i++) begin
      bus(32'h30000, 1'b0, 8'h00);
      n_total++; if (cpu_din !== exp_b[i]) $display("FAIL rx_rd%0d got %h exp %h", i, cpu_din, exp_b[i]); else n_pass++;
    end
    n_total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_low got %b exp 1", rx_ready); else n_pass++;
    // pop on empty with a simultaneous push
    rx_data = 8'h55; rx_valid = 1'b1;
    bus(32'h30000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    n_total++; if (cpu_din !== 8'h00) $display("FAIL rx_empty_pop got %h exp 00", cpu_din); else n_pass++;
    bus(32'h30000, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h55) $display("FAIL rx_kept_push got %h exp 55", cpu_din); else n_pass++;
    // push and pop together on a non-empty FIFO
    rx_push(8'h61);
    rx_data = 8'h62; rx_valid = 1'b1;
    bus(32'h30000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    n_total++; if (cpu_din !== 8'h61) $display("FAIL rx_simul_a got %h exp 61", cpu_din); else n_pass++;
    bus(32'h30000, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h62) $display("FAIL rx_simul_b got %h exp 62", cpu_din); else n_pass++;
    bus(32'h30000, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h00) $display("FAIL rx_simul_empty got %h exp 00", cpu_din); else n_pass++;
    // fill to full, one dropped byte, then drain
    for (int i = 0; i < 16; i++) rx_push(8'hA0 + 8'(i));
    n_total++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready got %b exp 0", rx_ready); else n_pass++;
    rx_push(8'hFF);
    for (int i = 0; i < 16; i++) begin
      bus(32'h30000, 1'b0, 8'h00);
      n_total++;
      if (cpu_din !== 8'hA0 + 8'(i)) $display("FAIL rx_drain%0d got %h exp %h", i, cpu_din, 8'hA0 + 8'(i));
      else n_pass++;
    end
    n_total++; if (rx_ready !== 1'b1) $display("FAIL rx_drained_ready got %b exp 1", rx_ready); else n_pass++;
    bus(32'h30000, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h00) $display("FAIL rx_dropped got %h exp 00", cpu_din); else n_pass++;
  endtask

  task automatic test_tx_backpressure();
    int c;
    tx_ready = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 16; i++) begin
      bus(32'h30000, 1'b1, 8'(i));
      exp_q.push_back(8'(i));
      if (i < 16) bus(32'h30000, 1'b1, 8'h00);
      if (i == 15) begin
        n_total++; if (cpu_rdy !== 1'b1) $display("FAIL tx_rdy_at15 got %b exp 1", cpu_rdy); else n_pass++;
      end
    end
    n_total++; if (cpu_rdy !== 1'b0) $display("FAIL tx_rdy_full got %b exp 0", cpu_rdy); else n_pass++;
    n_total++; if (tx_data !== 8'h01) $display("FAIL tx_head got %h exp 01", tx_data); else n_pass++;
    // stalled accesses must have no side effects
    cpu_wr = 1'b1;
    cpu_a = 32'h30000; cpu_dout = 8'h99; tick();
    cpu_a = 32'h00010; cpu_dout = 8'hEE; tick();
    cpu_a = 32'h30004; cpu_dout = 8'h01; tick();
    cpu_a = IDLE_A; cpu_wr = 1'b0; cpu_dout = 8'h00;
    n_total++; if (prog_done !== 1'b0) $display("FAIL stall_prog_done got %b exp 0", prog_done); else n_pass++;
    n_total++; if (cpu_rdy !== 1'b0) $display("FAIL stall_rdy got %b exp 0", cpu_rdy); else n_pass++;
    tx_ready = 1'b1;
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      if (tx_valid === 1'b1) begin
        n_total++;
        if (tx_data !== exp_q[0]) $display("FAIL tx_order got %h exp %h", tx_data, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
      tick();
      c++;
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL tx_drain_timeout got %0d left exp 0", exp_q.size()); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL tx_extra got valid %b data %h exp 0", tx_valid, tx_data); else n_pass++;
    n_total++; if (cpu_rdy !== 1'b1) $display("FAIL tx_rdy_back got %b exp 1", cpu_rdy); else n_pass++;
    bus(32'h10, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h5A) $display("FAIL stall_ram_wr got %h exp 5a", cpu_din); else n_pass++;
  endtask

  task automatic test_counter();
    logic [7:0] a, b;
    cpu_a = 32'h30004; cpu_wr = 1'b0;
    force dut.cnt = 32'h0000_01F4;
    #1 release dut.cnt;
    @(posedge clk_in); @(negedge clk_in);
    cpu_a = IDLE_A;
    n_total++; if (cpu_din !== 8'hF4) $display("FAIL cnt_b0 got %h exp f4", cpu_din); else n_pass++;
    tick(); tick(); tick();
    bus(32'h30005, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h01) $display("FAIL snap_b1 got %h exp 01", cpu_din); else n_pass++;
    bus(32'h30006, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h00) $display("FAIL snap_b2 got %h exp 00", cpu_din); else n_pass++;
    bus(32'h30007, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h00) $display("FAIL snap_b3 got %h exp 00", cpu_din); else n_pass++;
    bus(32'h30004, 1'b0, 8'h00); a = cpu_din;
    bus(32'h30004, 1'b0, 8'h00); b = cpu_din;
    n_total++; if (b !== a + 8'd1) $display("FAIL cnt_step got %h exp %h", b, a + 8'd1); else n_pass++;
    // wrap
    cpu_a = 32'h30004;
    force dut.cnt = 32'hFFFF_FFFF;
    #1 release dut.cnt;
    @(posedge clk_in); @(negedge clk_in);
    n_total++; if (cpu_din !== 8'hFF) $display("FAIL cnt_max got %h exp ff", cpu_din); else n_pass++;
    tick();
    n_total++; if (cpu_din !== 8'h00) $display("FAIL cnt_wrap got %h exp 00", cpu_din); else n_pass++;
    cpu_a = 32'h30007; tick();
    cpu_a = IDLE_A;
    n_total++; if (cpu_din !== 8'h00) $display("FAIL snap_wrap got %h exp 00", cpu_din); else n_pass++;
  endtask

  task automatic test_prog_done();
    tx_ready = 1'b1;
    bus(32'h30004, 1'b1, 8'hAB);
    n_total++; if (tx_valid !== 1'b1) $display("FAIL pd_tx_valid got %b exp 1", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL pd_tx_data got %h exp 00", tx_data); else n_pass++;
    n_total++; if (prog_done !== 1'b1) $display("FAIL pd_set got %b exp 1", prog_done); else n_pass++;
    tick();
    n_total++; if (tx_valid !== 1'b0) $display("FAIL pd_popped got %b exp 0", tx_valid); else n_pass++;
    bus(32'h30004, 1'b1, 8'hCD);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL pd_second_push got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (prog_done !== 1'b1) $display("FAIL pd_sticky got %b exp 1", prog_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus(32'h30000, 1'b1, 8'h20 + 8'(i));
    n_total++; if (tx_valid !== 1'b1) $display("FAIL mid_queued got %b exp 1", tx_valid); else n_pass++;
    bus(32'h10, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h5A) $display("FAIL mid_pre_rd got %h exp 5a", cpu_din); else n_pass++;
    #2 rst_n_in = 1'b0;
    #1;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL mid_tx_valid got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL mid_tx_data got %h exp 00", tx_data); else n_pass++;
    n_total++; if (cpu_din !== 8'h00) $display("FAIL mid_cpu_din got %h exp 00", cpu_din); else n_pass++;
    n_total++; if (prog_done !== 1'b0) $display("FAIL mid_prog_done got %b exp 0", prog_done); else n_pass++;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    bus(32'h10, 1'b0, 8'h00);
    n_total++; if (cpu_din !== 8'h5A) $display("FAIL mid_ram_kept got %h exp 5a", cpu_din); else n_pass++;
    tx_ready = 1'b1;
    tick();
    n_total++; if (tx_valid !== 1'b0) $display("FAIL mid_tx_flushed got %b exp 0", tx_valid); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ram();
    test_rx();
    test_tx_backpressure();
    test_counter();
    test_prog_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
